// File: rtl/panel_scan_sequencer.sv
// panel_scan_sequencer: row / PWM scan controller for one LED panel driver stage.
// Emits brightness shift/load, per-step LED value load, serial shift and
// panel latch strobes in a fixed cycle-exact order. Every output is a flop
// fed from the next-state decode, so output timing equals state timing.
module panel_scan_sequencer #(
    parameter int NUM_ROWS  = 16,
    parameter int ROW_BITS  = 4,
    parameter int SHIFT_LEN = 16,
    parameter int PWM_MAX   = 255,
    parameter int SETTLE    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                brightness_reload,
    output logic                shift,
    output logic                load_led_vals,
    output logic                load_brightness,
    output logic [7:0]          pwm_time,
    output logic [ROW_BITS-1:0] active_row_addr,
    output logic                panel_latch,
    output logic                row_blank,
    output logic                frame_start,
    output logic                busy
);

    localparam int CNT_MAX = (SHIFT_LEN > SETTLE) ? SHIFT_LEN : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]    SHIFT_LAST  = CNT_W'(SHIFT_LEN - 1);
    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [7:0]          PWM_LAST    = 8'(PWM_MAX);
    localparam logic [ROW_BITS-1:0] ROW_LAST    = ROW_BITS'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_BR_SHIFT, ST_BR_LOAD, ST_ROW_SETUP,
        ST_LOAD, ST_SHIFT, ST_LATCH, ST_ROW_END
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                bright_pending;
    logic                row_wrap;

    logic [ROW_BITS-1:0] row_d;
    logic [7:0]          pwm_d;
    logic                blank_d;
    logic                fs_d;

    assign row_wrap = (active_row_addr == ROW_LAST);

    // State register plus the in-state cycle counter (restarts on every state change)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q || state_q == ST_IDLE) ? '0 : cnt_q + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (enable) state_d = bright_pending ? ST_BR_SHIFT : ST_ROW_SETUP;
            ST_BR_SHIFT:  if (cnt_q == SHIFT_LAST) state_d = ST_BR_LOAD;
            ST_BR_LOAD:   state_d = ST_ROW_SETUP;
            ST_ROW_SETUP: if (cnt_q == SETTLE_LAST) state_d = ST_LOAD;
            ST_LOAD:      state_d = ST_SHIFT;
            ST_SHIFT:     if (cnt_q == SHIFT_LAST) state_d = ST_LATCH;
            ST_LATCH:     state_d = (pwm_time < PWM_LAST) ? ST_LOAD : ST_ROW_END;
            ST_ROW_END: begin
                // Brightness is only reloaded at a frame boundary (wrap to row 0)
                if (!enable)                        state_d = ST_IDLE;
                else if (row_wrap && bright_pending) state_d = ST_BR_SHIFT;
                else                                 state_d = ST_ROW_SETUP;
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values derived from the upcoming state
    always_comb begin
        row_d = active_row_addr;
        if (state_q == ST_ROW_END)
            row_d = row_wrap ? '0 : active_row_addr + 1'b1;

        // pwm_time holds through LOAD..LATCH and ROW_END; zero everywhere else
        pwm_d = '0;
        if (state_q == ST_LATCH && state_d == ST_LOAD)
            pwm_d = pwm_time + 8'd1;
        else if (state_d inside {ST_LOAD, ST_SHIFT, ST_LATCH, ST_ROW_END})
            pwm_d = pwm_time;

        // Panel lights only after the first latch of a row has presented data
        blank_d = row_blank;
        if (state_d inside {ST_IDLE, ST_BR_SHIFT, ST_BR_LOAD, ST_ROW_SETUP, ST_ROW_END})
            blank_d = 1'b1;
        else if (state_q == ST_LATCH)
            blank_d = 1'b0;

        fs_d = (state_d == ST_ROW_SETUP) && (state_q != ST_ROW_SETUP) && (row_d == '0);
    end

    // Registered outputs and the pending-brightness flag
    always_ff @(posedge clk) begin
        if (reset) begin
            shift           <= 1'b0;
            load_led_vals   <= 1'b0;
            load_brightness <= 1'b0;
            panel_latch     <= 1'b0;
            frame_start     <= 1'b0;
            busy            <= 1'b0;
            pwm_time        <= '0;
            active_row_addr <= '0;
            row_blank       <= 1'b1;
            bright_pending  <= 1'b1;
        end else begin
            shift           <= (state_d == ST_BR_SHIFT) || (state_d == ST_SHIFT);
            load_led_vals   <= (state_d == ST_LOAD);
            load_brightness <= (state_d == ST_BR_LOAD);
            panel_latch     <= (state_d == ST_LATCH);
            frame_start     <= fs_d;
            busy            <= (state_d != ST_IDLE);
            pwm_time        <= pwm_d;
            active_row_addr <= row_d;
            row_blank       <= blank_d;
            // A reload arriving in the very cycle the load happens stays pending
            bright_pending  <= brightness_reload | (bright_pending & (state_q != ST_BR_LOAD));
        end
    end

endmodule

// File: tb/tb_panel_scan_sequencer.sv
// Directed bench for panel_scan_sequencer (SHIFT_LEN=16, PWM_MAX=3, SETTLE=2).
// Cycle n is counted from the cycle in which enable is first raised (cycle 0);
// one row is 75 cycles, row 0 of frame 0 begins ROW_SETUP at cycle 18.
module tb_panel_scan_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       brightness_reload;
    logic       shift, load_led_vals, load_brightness, panel_latch;
    logic [7:0] pwm_time;
    logic [3:0] active_row_addr;
    logic       row_blank, frame_start, busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int shift_cnt = 0, lb_cnt = 0, fs_cnt = 0, excl_err = 0;

    panel_scan_sequencer #(
        .NUM_ROWS(16), .ROW_BITS(4), .SHIFT_LEN(16), .PWM_MAX(3), .SETTLE(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .brightness_reload(brightness_reload),
        .shift(shift), .load_led_vals(load_led_vals), .load_brightness(load_brightness),
        .pwm_time(pwm_time), .active_row_addr(active_row_addr), .panel_latch(panel_latch),
        .row_blank(row_blank), .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    // Strobe counters and exclusivity watch, sampled mid-cycle
    always @(negedge clk) begin
        shift_cnt <= shift_cnt + int'(shift);
        lb_cnt    <= lb_cnt + int'(load_brightness);
        fs_cnt    <= fs_cnt + int'(frame_start);
        if (int'(shift) + int'(load_led_vals) + int'(load_brightness) + int'(panel_latch) > 1)
            excl_err <= excl_err + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic check_strobes(input string tag, input int s, input int llv, input int lb, input int pl);
        check({tag, ".shift"}, int'(shift), s);
        check({tag, ".load_led_vals"}, int'(load_led_vals), llv);
        check({tag, ".load_brightness"}, int'(load_brightness), lb);
        check({tag, ".panel_latch"}, int'(panel_latch), pl);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; brightness_reload = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        repeat (6) step();

        // Idle after reset with enable low
        check_strobes("idle", 0, 0, 0, 0);
        check("idle.row_blank", int'(row_blank), 1);
        check("idle.busy", int'(busy), 0);
        check("idle.row", int'(active_row_addr), 0);
        check("idle.pwm", int'(pwm_time), 0);
        check("idle.frame_start", int'(frame_start), 0);

        // Cycle 0: enable raised; brightness pending from reset
        cyc = 0;
        enable = 1'b1;
        shift_cnt = 0; lb_cnt = 0;
        step();
        check_strobes("c1", 1, 0, 0, 0);
        check("c1.busy", int'(busy), 1);
        check("c1.row_blank", int'(row_blank), 1);
        run_to(16); check_strobes("c16", 1, 0, 0, 0);
        run_to(17); check_strobes("c17", 0, 0, 1, 0);
        check("c1_17.shift_count", shift_cnt, 16);
        run_to(18);
        check("c18.frame_start", int'(frame_start), 1);
        check("c18.row_blank", int'(row_blank), 1);
        check_strobes("c18", 0, 0, 0, 0);
        run_to(19); check("c19.frame_start", int'(frame_start), 0);
        run_to(20); check_strobes("c20", 0, 1, 0, 0);
        check("c20.pwm", int'(pwm_time), 0);
        run_to(36); check_strobes("c36", 1, 0, 0, 0);
        run_to(37); check_strobes("c37", 0, 0, 0, 1);
        check("c37.pwm", int'(pwm_time), 0);
        check("c37.row_blank", int'(row_blank), 1);
        run_to(38); check("c38.row_blank", int'(row_blank), 0);
        check_strobes("c38", 0, 1, 0, 0);
        check("c38.pwm", int'(pwm_time), 1);
        run_to(55); check_strobes("c55", 0, 0, 0, 1); check("c55.pwm", int'(pwm_time), 1);
        run_to(73); check_strobes("c73", 0, 0, 0, 1); check("c73.pwm", int'(pwm_time), 2);
        run_to(91); check_strobes("c91", 0, 0, 0, 1); check("c91.pwm", int'(pwm_time), 3);
        check("c91.row_blank", int'(row_blank), 0);
        run_to(92);
        check_strobes("c92", 0, 0, 0, 0);
        check("c92.row_blank", int'(row_blank), 1);
        check("c92.row", int'(active_row_addr), 0);
        run_to(93);
        check("c93.row", int'(active_row_addr), 1);
        check("c93.frame_start", int'(frame_start), 0);
        check("c93.row_blank", int'(row_blank), 1);

        // Full frame and wrap to row 0 without brightness reload
        fs_cnt = 0; lb_cnt = 0;
        run_to(1217); check("c1217.row", int'(active_row_addr), 15);
        run_to(1218);
        check("c1218.row", int'(active_row_addr), 0);
        check("c1218.frame_start", int'(frame_start), 1);
        check_strobes("c1218", 0, 0, 0, 0);
        run_to(1220); check_strobes("c1220", 0, 1, 0, 0);
        check("frame1.frame_start_count", fs_cnt, 1);
        check("frame1.load_brightness_count", lb_cnt, 0);

        // Reload request during row 5 of frame 1, serviced only at wrap
        run_to(1600);
        check("c1600.row", int'(active_row_addr), 5);
        brightness_reload = 1'b1;
        step();
        brightness_reload = 1'b0;
        lb_cnt = 0;
        run_to(2417);
        check("c2417.row", int'(active_row_addr), 15);
        run_to(2418);
        check("reload.deferred_lb_count", lb_cnt, 0);
        check_strobes("c2418", 1, 0, 0, 0);
        check("c2418.row", int'(active_row_addr), 0);
        check("c2418.frame_start", int'(frame_start), 0);
        shift_cnt = 0; lb_cnt = 0;
        run_to(2434); check_strobes("c2434", 0, 0, 1, 0);
        run_to(2435);
        check("reload.shift_count", shift_cnt, 16);
        check("reload.lb_count", lb_cnt, 1);
        check("c2435.frame_start", int'(frame_start), 1);

        // Drop enable during row 3 pwm step 1; row completes then IDLE
        run_to(2685);
        check("c2685.row", int'(active_row_addr), 3);
        check("c2685.pwm", int'(pwm_time), 1);
        enable = 1'b0;
        run_to(2733); check_strobes("c2733", 0, 0, 0, 1); check("c2733.pwm", int'(pwm_time), 3);
        run_to(2734); check("c2734.busy", int'(busy), 1); check("c2734.row", int'(active_row_addr), 3);
        run_to(2735);
        check("c2735.busy", int'(busy), 0);
        check("c2735.row", int'(active_row_addr), 4);
        check("c2735.row_blank", int'(row_blank), 1);
        run_to(2740);
        check("c2740.busy", int'(busy), 0);
        check_strobes("c2740", 0, 0, 0, 0);
        enable = 1'b1;
        lb_cnt = 0;
        step();
        check("c2741.busy", int'(busy), 1);
        check("c2741.row", int'(active_row_addr), 4);
        check("c2741.frame_start", int'(frame_start), 0);
        check_strobes("c2741", 0, 0, 0, 0);
        run_to(2743); check_strobes("c2743", 0, 1, 0, 0);
        run_to(2750); check_strobes("c2750", 1, 0, 0, 0);
        check("resume.lb_count", lb_cnt, 0);

        // Synchronous reset in the middle of SHIFT
        reset = 1'b1;
        step();
        check_strobes("rst", 0, 0, 0, 0);
        check("rst.busy", int'(busy), 0);
        check("rst.row_blank", int'(row_blank), 1);
        check("rst.row", int'(active_row_addr), 0);
        check("rst.pwm", int'(pwm_time), 0);
        check("rst.frame_start", int'(frame_start), 0);
        check("rst.bright_pending", int'(dut.bright_pending), 1);
        reset = 1'b0;
        step();
        check_strobes("c2752", 1, 0, 0, 0);
        run_to(2767); check_strobes("c2767", 1, 0, 0, 0);
        run_to(2768); check_strobes("c2768", 0, 0, 1, 0);
        run_to(2769); check("c2769.frame_start", int'(frame_start), 1);

        step();
        check("strobe_exclusive_violations", excl_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/panel_scan_sequencer.md
Name: panel_scan_sequencer

Overview:
- Generates the scan and PWM control sequence for one LED panel driver stage.
- Selects the active row (`active_row_addr`) and steps `pwm_time` through all PWM levels for that row.
- Issues `load_led_vals`, `shift`, `load_brightness` and panel latch/blank strobes in a fixed, cycle-exact order.
- Sits directly upstream of the panel driver, which consumes every strobe; row RAM writes are handled elsewhere and are not touched here.

Parameters:
- NUM_ROWS, 16, rows scanned per frame; `active_row_addr` wraps NUM_ROWS-1 -> 0.
- ROW_BITS, 4, width of `active_row_addr`.
- SHIFT_LEN, 16, shift cycles per serial transfer (bits per serial line).
- PWM_MAX, 255, last `pwm_time` value per row (8-bit, max 255).
- SETTLE, 2, cycles waited after a row change before the first `load_led_vals` (row RAM read latency).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = run scan, 0 = stop at next row boundary.
- brightness_reload  in  1  single-cycle pulse; requests a brightness reload.
- shift  out  1  shift strobe to driver, one bit per high cycle.
- load_led_vals  out  1  one-cycle parallel load of PWM comparison bits.
- load_brightness  out  1  one-cycle load of brightness register.
- pwm_time  out  8  current PWM level.
- active_row_addr  out  ROW_BITS  row being read and displayed.
- panel_latch  out  1  one-cycle latch strobe to panel shift registers.
- row_blank  out  1  1 = panel outputs off.
- frame_start  out  1  one-cycle pulse when row 0 begins.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset values:
  - `shift`, `load_led_vals`, `load_brightness`, `panel_latch`, `frame_start`, `busy` = 0.
  - `pwm_time` = 0, `active_row_addr` = 0, `row_blank` = 1.
  - Internal `bright_pending` = 1.
- Reset mid-operation: same values on the next edge, regardless of state.
- All outputs are registered.
- States:
  - IDLE
  - BR_SHIFT
  - BR_LOAD
  - ROW_SETUP
  - LOAD
  - SHIFT
  - LATCH
  - ROW_END
- IDLE:
  - `row_blank` = 1.
  - On `enable` = 1: go to BR_SHIFT if `bright_pending`, else ROW_SETUP.
- BR_SHIFT:
  - `shift` = 1 for exactly SHIFT_LEN consecutive cycles, then BR_LOAD.
- BR_LOAD:
  - `load_brightness` = 1 for one cycle.
  - Clear `bright_pending`, unless `brightness_reload` is asserted that same cycle (pending stays set).
  - Then go to ROW_SETUP.
- ROW_SETUP:
  - `row_blank` = 1; `active_row_addr` is stable.
  - Hold SETTLE cycles; `pwm_time` = 0.
  - `frame_start` = 1 on the first cycle of ROW_SETUP when `active_row_addr` = 0.
  - Then go to LOAD.
- LOAD: `load_led_vals` = 1 for one cycle, then SHIFT.
- SHIFT: `shift` = 1 for SHIFT_LEN cycles, then LATCH.
- LATCH:
  - `panel_latch` = 1 for one cycle.
  - From the cycle after the first LATCH of a row, `row_blank` = 0.
  - If `pwm_time` < PWM_MAX: increment `pwm_time` and go to LOAD.
  - Otherwise go to ROW_END.
- `pwm_time` is constant from LOAD through LATCH of each step.
- ROW_END (one cycle):
  - `row_blank` = 1.
  - Increment `active_row_addr`, wrapping NUM_ROWS-1 -> 0.
  - If not wrapping: go to ROW_SETUP if `enable`, else IDLE.
  - If wrapping: go to BR_SHIFT if (`enable` and `bright_pending`), ROW_SETUP if `enable` only, else IDLE.
- Cycle counts:
  - One PWM step = SHIFT_LEN + 2 cycles.
  - One row = SETTLE + (PWM_MAX + 1) × (SHIFT_LEN + 2) + 1 cycles.
- `brightness_reload` in any state sets `bright_pending`; it is serviced only at a frame boundary or on exit from IDLE.
- `enable` falling mid-row: the current row completes in full, then IDLE. Rows are never truncated.
- `enable` re-asserted while in IDLE: resume at the stored `active_row_addr`, not at row 0.
- Strobe exclusivity: `shift`, `load_led_vals`, `load_brightness` and `panel_latch` are mutually exclusive; at most one is high in any cycle.

Test Plan:
- Reset held 3 cycles, then released with `enable` = 0 -> all strobes 0, `row_blank` = 1, `busy` = 0, `active_row_addr` = 0, `pwm_time` = 0 indefinitely.
- Params SHIFT_LEN=16, PWM_MAX=3, SETTLE=2; `enable` = 1 at cycle 0 after reset ->
  - `shift` high cycles 1–16, `load_brightness` at cycle 17.
  - `frame_start` at cycle 18.
  - First `load_led_vals` at cycle 20 with `pwm_time` = 0.
  - LATCH cycles at 37, 55, 73, 91 with `pwm_time` 0, 1, 2, 3.
  - ROW_END at 92, `active_row_addr` = 1 at cycle 93.
- Same params, run 16 rows -> `active_row_addr` wraps 15 -> 0; `frame_start` pulses exactly once per 16 rows; no `load_brightness` on the second frame.
- `brightness_reload` pulsed during row 5 -> no `load_brightness` until after ROW_END of row 15; then exactly 16 `shift` cycles + 1 `load_brightness` before row 0 ROW_SETUP.
- `enable` dropped during row 3 step `pwm_time` = 1 -> row 3 completes through `pwm_time` = 3, then IDLE with `row_blank` = 1 and `active_row_addr` = 4; re-enable resumes at row 4 with no brightness reload.
- Synchronous `reset` asserted mid-SHIFT -> next edge: all outputs at reset values, `bright_pending` = 1; on re-enable a brightness reload occurs first.
